// File: rtl/vga_pixel_packer_if.sv
// vga_pixel_packer_if: pixel-stream input, FIFO write port and status outputs
// of the VGA write-side pixel packer.
//
// Flow control: pix_valid qualifies pix_sof/pix_r/pix_g/pix_b for one vga_clk
// cycle and there is no ready. The packer accepts every valid pixel. fifo_full
// is sampled on the cycle a word completes; a full FIFO makes the packer
// discard that word rather than stall. fifo_wr_en is a one-cycle strobe that
// qualifies fifo_wr_data.
interface vga_pixel_packer_if #(
  parameter int WCNT_W = 16
);
  logic              pix_valid;
  logic              pix_sof;
  logic [7:0]        pix_r;
  logic [7:0]        pix_g;
  logic [7:0]        pix_b;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [127:0]      fifo_wr_data;
  logic              status_clr;
  logic              overflow;
  logic              frame_err;
  logic [WCNT_W-1:0] frame_words;
  logic              frame_done;

  // Pixel source / FIFO / status consumer side.
  modport master (
    output pix_valid, pix_sof, pix_r, pix_g, pix_b, fifo_full, status_clr,
    input  fifo_wr_en, fifo_wr_data, overflow, frame_err, frame_words, frame_done
  );

  // Packer side.
  modport slave (
    input  pix_valid, pix_sof, pix_r, pix_g, pix_b, fifo_full, status_clr,
    output fifo_wr_en, fifo_wr_data, overflow, frame_err, frame_words, frame_done
  );
endinterface

// File: rtl/vga_pixel_packer.sv
// vga_pixel_packer: packs a 24-bit RGB pixel stream four pixels per 128-bit
// word (lane k = bits [32k+31:32k] = {ALPHA, B, G, R}) for the DDR-bound pixel
// FIFO. A word that completes while the FIFO is full is dropped and packing
// resumes at the next frame start. Per-frame written-word counts and sticky
// overflow / frame-error flags are reported.
//
// Optional build macro VGA_PACK_TESTPAT_EN: lanes carry a per-frame pixel
// index pattern instead of the input colour, so the display path can check
// itself.
module vga_pixel_packer #(
  parameter logic [7:0] ALPHA  = 8'h00,
  parameter int         WCNT_W = 16
) (
  input  logic                    vga_clk,
  input  logic                    vga_reset_n,
  vga_pixel_packer_if.slave       pif,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_lane;
  logic [95:0]       r_acc;
  logic              r_wr_en;
  logic [127:0]      r_wr_data;
  logic              r_overflow;
  logic              r_frame_err;
  logic [WCNT_W-1:0] r_frame_words;
  logic              r_frame_done;
  logic [WCNT_W-1:0] r_word_cnt;

  logic              w_sof;
  logic [31:0]       w_lane_px;

  // SOF only counts when it rides on a valid pixel.
  assign w_sof = pif.pix_valid & pif.pix_sof;

`ifdef VGA_PACK_TESTPAT_EN
  logic [23:0] r_pat_cnt;
  logic [23:0] w_pat;

  // The SOF pixel is pattern value 0, so a frame carries 0,1,2,... in order.
  assign w_pat     = w_sof ? 24'd0 : r_pat_cnt;
  assign w_lane_px = {ALPHA, w_pat[23:16], w_pat[15:8], w_pat[7:0]};

  // Pattern counter: restarts on SOF, advances on every pixel packed in RUN.
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      r_pat_cnt <= 24'd0;
    end else if (w_sof) begin
      r_pat_cnt <= 24'd1;
    end else if (pif.pix_valid && (r_state == S_RUN)) begin
      r_pat_cnt <= r_pat_cnt + 24'd1;
    end
  end
`else
  assign w_lane_px = {ALPHA, pif.pix_b, pif.pix_g, pif.pix_r};
`endif

  // Packing FSM: lane fill, word emit or drop, frame accounting, sticky flags.
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      r_state       <= S_IDLE;
      r_lane        <= 2'd0;
      r_acc         <= 96'd0;
      r_wr_en       <= 1'b0;
      r_wr_data     <= 128'd0;
      r_overflow    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_words <= '0;
      r_frame_done  <= 1'b0;
      r_word_cnt    <= '0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (pif.status_clr) begin
        r_overflow  <= 1'b0;
        r_frame_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          // First SOF after reset: no previous frame to report.
          if (w_sof) begin
            r_acc[31:0] <= w_lane_px;
            r_lane      <= 2'd1;
            r_word_cnt  <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_sof) begin
            // The counter already includes a word completed last cycle.
            r_frame_words <= r_word_cnt;
            r_frame_done  <= 1'b1;
            r_word_cnt    <= '0;
            if (r_lane != 2'd0) begin
              r_frame_err <= 1'b1;
            end
            r_acc[31:0]   <= w_lane_px;
            r_lane        <= 2'd1;
          end else if (pif.pix_valid) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_acc[31:0]  <= w_lane_px;
              2'd1: r_acc[63:32] <= w_lane_px;
              2'd2: r_acc[95:64] <= w_lane_px;
              default: begin
                if (!pif.fifo_full) begin
                  r_wr_en   <= 1'b1;
                  r_wr_data <= {w_lane_px, r_acc};
                  if (r_word_cnt != '1) begin
                    r_word_cnt <= r_word_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
                  end
                end else begin
                  r_overflow <= 1'b1;
                  r_state    <= S_DROP;
                end
              end
            endcase
          end
        end
        S_DROP: begin
          // Lane count wrapped to 0 on the dropped word, so no frame error here.
          if (w_sof) begin
            r_frame_words <= r_word_cnt;
            r_frame_done  <= 1'b1;
            r_word_cnt    <= '0;
            r_acc[31:0]   <= w_lane_px;
            r_lane        <= 2'd1;
            r_state       <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pif.fifo_wr_en   = r_wr_en;
  assign pif.fifo_wr_data = r_wr_data;
  assign pif.overflow     = r_overflow;
  assign pif.frame_err    = r_frame_err;
  assign pif.frame_words  = r_frame_words;
  assign pif.frame_done   = r_frame_done;
  assign o_dbg_state      = r_state;

endmodule
